// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the DRAM request arbiter.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request above ptr, wrapping.
module rr_arbiter
  import dram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_req_arbiter.sv
// Shares one dram_controller user port between NUM_REQ requesters,
// one transaction at a time, with an optional ack watchdog.
module dram_req_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_err,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      read,
  output logic                      write,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         write_data,
  input  logic [DATA_W-1:0]         read_data,
  input  logic                      ack,
  input  logic                      busy
);

  localparam int IW = clog2(NUM_REQ);
  localparam int WW = clog2(TIMEOUT_CYC + 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, idx_q;
  logic                we_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [WW-1:0]       wd_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;
  logic                grant;
  logic                expire;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign grant  = (state_q == IDLE) && !busy && gnt_any;
  assign expire = (TIMEOUT_CYC != 0) &&
                  (wd_q == WW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (grant) state_d = CMD;
      CMD:  if (ack || expire) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= IW'(NUM_REQ - 1);
      idx_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wd_q    <= '0;
    end else begin
      if (grant) begin
        ptr_q   <= gnt_idx;
        idx_q   <= gnt_idx;
        we_q    <= req_we[gnt_idx];
        addr_q  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[gnt_idx*DATA_W +: DATA_W];
      end
      if (state_q == CMD) begin
        wd_q <= wd_q + 1'b1;
        // ack takes priority over a simultaneous watchdog expiry
        if (ack) begin
          rdata_q <= read_data;
          err_q   <= 1'b0;
        end else if (expire) begin
          err_q   <= 1'b1;
        end
      end
      if (state_q == DONE) wd_q <= '0;
    end
  end

  assign read       = (state_q == CMD) && !we_q;
  assign write      = (state_q == CMD) && we_q;
  assign address    = addr_q;
  assign write_data = wdata_q;
  assign req_ready  = (grant && rst_ni) ? gnt : '0;
  assign resp_valid = (state_q == DONE) ?
                      (NUM_REQ'(1) << idx_q) : '0;
  assign resp_err   = (state_q == DONE) && err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed bench for dram_req_arbiter: grants, routing, busy,
// watchdog and reset behaviour.
module tb_dram_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 26;
  localparam int DW = 128;
  localparam int TO = 24;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  resp_valid;
  logic           resp_err;
  logic [DW-1:0]  resp_rdata;
  logic           read;
  logic           write;
  logic [AW-1:0]  address;
  logic [DW-1:0]  write_data;
  logic [DW-1:0]  read_data;
  logic           ack;
  logic           busy;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_addr [NR];
  logic [DW-1:0] exp_wd   [NR];

  always #5 clk_i = ~clk_i;

  dram_req_arbiter #(
    .NUM_REQ     (NR),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .read       (read),
    .write      (write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ack        (ack),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    req_valid = '0;
    req_we    = '0;
    ack       = 1'b0;
    busy      = 1'b0;
    read_data = '0;
    repeat (3) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=0000", req_ready);
    end
    do_reset();
    #1;
    total++;
    if ({read, write, req_ready, resp_valid, resp_err} !== 11'd0) begin
      bad++;
      $display("FAIL rst_ctl got=%b exp=0",
               {read, write, req_ready, resp_valid, resp_err});
    end
    total++;
    if ({address, write_data, resp_rdata} !== '0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h exp=0", address, resp_rdata);
    end
  endtask

  task automatic test_single_read();
    logic [DW-1:0] d;
    d = {4{32'hDEADBEEF}};
    req_we    = 4'b0000;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL rd_ready got=%b exp=0100", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if ({read, write} !== 2'b10 || address !== 26'h0123456) begin
      bad++;
      $display("FAIL rd_cmd got=%b%b/%h exp=10/0123456",
               read, write, address);
    end
    read_data = d;
    repeat (19) tick();
    total++;
    if (read !== 1'b1) begin
      bad++;
      $display("FAIL rd_hold got=%b exp=1", read);
    end
    ack = 1'b1;
    tick();
    ack       = 1'b0;
    read_data = '0;
    total++;
    if (resp_valid !== 4'b0100 || resp_err !== 1'b0 || read !== 1'b0) begin
      bad++;
      $display("FAIL rd_resp got=%b/%b/%b exp=0100/0/0",
               resp_valid, resp_err, read);
    end
    total++;
    if (resp_rdata !== d) begin
      bad++;
      $display("FAIL rd_data got=%h exp=%h", resp_rdata, d);
    end
    tick();
    total++;
    if (resp_valid !== 4'b0000) begin
      bad++;
      $display("FAIL rd_pulse got=%b exp=0000", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    req_we    = '0;
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      e = n % NR;
      #1;
      total++;
      if (req_ready !== (4'b0001 << e)) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b exp=%b",
                 n, req_ready, 4'b0001 << e);
      end
      tick();
      total++;
      if (read !== 1'b1 || address !== exp_addr[e]) begin
        bad++;
        $display("FAIL rr_addr%0d got=%b/%h exp=1/%h",
                 n, read, address, exp_addr[e]);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      total++;
      if (resp_valid !== (4'b0001 << e) || req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL rr_resp%0d got=%b/%b exp=%b/0000",
                 n, resp_valid, req_ready, 4'b0001 << e);
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_busy();
    logic seen;
    do_reset();
    busy      = 1'b1;
    req_we    = '0;
    req_valid = 4'b0001;
    seen      = 1'b0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (req_ready !== 4'b0000 || read !== 1'b0 || write !== 1'b0)
        seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL busy_block got=1 exp=0");
    end
    busy = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL busy_grant got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if (read !== 1'b1) begin
      bad++;
      $display("FAIL busy_read got=%b exp=1", read);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  task automatic test_write();
    req_we    = 4'b0010;
    req_valid = 4'b0010;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL wr_ready got=%b exp=0010", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if ({read, write} !== 2'b01 || write_data !== exp_wd[1]) begin
      bad++;
      $display("FAIL wr_cmd got=%b%b/%h exp=01/%h",
               read, write, write_data, exp_wd[1]);
    end
    ack = 1'b1;
    tick();
    ack       = 1'b0;
    req_valid = 4'b0010;
    total++;
    if (resp_valid !== 4'b0010 || write !== 1'b0 || resp_err !== 1'b0) begin
      bad++;
      $display("FAIL wr_resp got=%b/%b/%b exp=0010/0/0",
               resp_valid, write, resp_err);
    end
    tick();
    #1;
    total++;
    if (write !== 1'b0 || req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL wr_gap got=%b/%b exp=0/0010", write, req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if (write !== 1'b1) begin
      bad++;
      $display("FAIL wr_again got=%b exp=1", write);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  task automatic test_watchdog();
    logic drop;
    logic [DW-1:0] q;
    q = {4{32'hC0FFEE01}};
    do_reset();
    req_we    = '0;
    req_valid = 4'b0110;
    read_data = {4{32'h12345678}};
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL wd_grant got=%b exp=0010", req_ready);
    end
    tick();
    req_valid = 4'b0100;
    drop      = 1'b0;
    for (int c = 0; c < TO; c++) begin
      if (read !== 1'b1) drop = 1'b1;
      tick();
    end
    total++;
    if (drop !== 1'b0) begin
      bad++;
      $display("FAIL wd_hold got=1 exp=0");
    end
    total++;
    if (read !== 1'b0 || resp_valid !== 4'b0010 || resp_err !== 1'b1) begin
      bad++;
      $display("FAIL wd_abort got=%b/%b/%b exp=0/0010/1",
               read, resp_valid, resp_err);
    end
    total++;
    if (resp_rdata !== '0) begin
      bad++;
      $display("FAIL wd_rdata got=%h exp=0", resp_rdata);
    end
    tick();
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL wd_next got=%b exp=0100", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (TO - 1) tick();
    total++;
    if (read !== 1'b1) begin
      bad++;
      $display("FAIL wd_edge_read got=%b exp=1", read);
    end
    read_data = q;
    ack       = 1'b1;
    tick();
    ack = 1'b0;
    total++;
    if (resp_valid !== 4'b0100 || resp_err !== 1'b0 || resp_rdata !== q) begin
      bad++;
      $display("FAIL wd_tie got=%b/%b/%h exp=0100/0/%h",
               resp_valid, resp_err, resp_rdata, q);
    end
    tick();
  endtask

  task automatic test_spurious_ack();
    logic seen;
    seen = 1'b0;
    ack  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (resp_valid !== 4'b0000 || read !== 1'b0) seen = 1'b1;
    end
    ack = 1'b0;
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL spur_ack got=1 exp=0");
    end
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    req_we    = '0;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    total++;
    if (read !== 1'b1) begin
      bad++;
      $display("FAIL mid_cmd got=%b exp=1", read);
    end
    #4;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({read, write, resp_valid} !== 6'd0) begin
      bad++;
      $display("FAIL mid_async got=%b exp=0",
               {read, write, resp_valid});
    end
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i);
      #1;
      if (resp_valid !== 4'b0000) seen = 1'b1;
    end
    #1;
    rst_ni    = 1'b1;
    req_valid = 4'b0101;
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL mid_noresp got=1 exp=0");
    end
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL mid_first got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if (read !== 1'b1 || address !== exp_addr[0]) begin
      bad++;
      $display("FAIL mid_addr got=%b/%h exp=1/%h",
               read, address, exp_addr[0]);
    end
  endtask

  initial begin
    exp_addr[0] = 26'h0000100;
    exp_addr[1] = 26'h1111110;
    exp_addr[2] = 26'h0123456;
    exp_addr[3] = 26'h3FFFFFF;
    exp_wd[0]   = {4{32'h00000000}};
    exp_wd[1]   = {16{8'hA5}};
    exp_wd[2]   = {4{32'h22222222}};
    exp_wd[3]   = {4{32'h33333333}};
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = exp_addr[i];
      req_wdata[i*DW +: DW] = exp_wd[i];
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_busy();
    test_write();
    test_watchdog();
    test_spurious_ack();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
